// File: rtl/hx8357_fill_sequencer.sv
// -----------------------------------------------------------------------------
// hx8357_fill_sequencer
//
// Brings an HX8357 panel out of reset (SLPOUT, COLMOD=RGB565, DISPON) and then
// fills rectangular windows on request, either with a constant RGB565 color or
// with pixels taken from a valid/ready stream. Words are handed to an external
// write controller one at a time; a word counts as sent only when the
// controller returns a one-cycle transmission_cmpl pulse.
//
// Parameters
//   PWR_DELAY          cycles waited after reset before SLPOUT (>= 1)
//   SLP_DELAY          cycles waited after SLPOUT completes (>= 1)
//
// Ports
//   clk                sole clock, rising edge
//   res                synchronous active-high reset
//   start              one-cycle fill request (honoured only in IDLE)
//   x0, x1, y0, y1     inclusive window bounds, sampled with start
//   src_sel            0 = constant color, 1 = pixel stream; sampled with start
//   color              constant pixel value, sampled with start
//   pix_data/valid     stream pixel input
//   pix_ready          stream pixel accepted when pix_valid && pix_ready
//   init_done          panel initialised; stays high until reset
//   busy               high in every state except IDLE
//   done               one-cycle pulse after the last pixel of a fill
//   err                one-cycle pulse after a rejected start
//   cmd, data          request lines to the write controller (never both high)
//   data_in            word presented to the write controller
//   transmission_cmpl  one-cycle pulse: current word latched by the controller
// -----------------------------------------------------------------------------
module hx8357_fill_sequencer #(
    parameter int unsigned PWR_DELAY = 600000,
    parameter int unsigned SLP_DELAY = 6000000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic        src_sel,
    input  logic [15:0] color,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        init_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cmd,
    output logic        data,
    output logic [15:0] data_in,
    input  logic        transmission_cmpl
);

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_SLPOUT,
        S_WAIT_SLP,
        S_COLMOD,
        S_DISPON,
        S_IDLE,
        S_WIN,
        S_PIXELS
    } state_t;

    localparam logic [15:0] CMD_SLPOUT = 16'h0011;
    localparam logic [15:0] CMD_COLMOD = 16'h003A;
    localparam logic [15:0] PAR_COLMOD = 16'h0055;
    localparam logic [15:0] CMD_DISPON = 16'h0029;
    localparam logic [3:0]  WIN_LAST   = 4'd10;

    state_t       state_q, state_d;
    logic [31:0]  dly_q;
    logic [3:0]   idx_q;
    logic [8:0]   x0_q, x1_q, y0_q, y1_q;
    logic         src_sel_q;
    logic [15:0]  color_q;
    logic [17:0]  rem_q;       // pixels still to be sent
    logic [17:0]  fetch_q;     // stream pixels still to be accepted
    logic [1:0]   ent_q;       // prefetch buffer occupancy
    logic [15:0]  pbuf_q [2];  // [0] is the head
    logic         init_done_q, done_q, err_q;

    logic         tc;
    logic         win_ok, start_ok, start_bad;
    logic         dly_hit;
    logic         pix_avail, pix_pulse, last_pix, accept;
    logic [8:0]   xw, yw;
    logic [17:0]  npix;
    logic [16:0]  ww;

    assign tc = transmission_cmpl;

    // Window setup word i as {is_cmd, word}; parameters are zero-extended.
    function automatic logic [16:0] win_word(input logic [3:0] i,
                                             input logic [8:0] a0, input logic [8:0] a1,
                                             input logic [8:0] b0, input logic [8:0] b1);
        case (i)
            4'd0:    return {1'b1, 16'h002A};
            4'd1:    return {1'b0, 15'd0, a0[8]};
            4'd2:    return {1'b0, 8'd0, a0[7:0]};
            4'd3:    return {1'b0, 15'd0, a1[8]};
            4'd4:    return {1'b0, 8'd0, a1[7:0]};
            4'd5:    return {1'b1, 16'h002B};
            4'd6:    return {1'b0, 15'd0, b0[8]};
            4'd7:    return {1'b0, 8'd0, b0[7:0]};
            4'd8:    return {1'b0, 15'd0, b1[8]};
            4'd9:    return {1'b0, 8'd0, b1[7:0]};
            default: return {1'b1, 16'h002C};
        endcase
    endfunction

    // ---------------------------------------------------------------- requests
    assign win_ok    = (x1 >= x0) && (y1 >= y0) && (x1 <= 9'd319) && (y1 <= 9'd479);
    assign start_ok  = (state_q == S_IDLE) && init_done_q && start && win_ok;
    assign start_bad = (state_q == S_IDLE) && init_done_q && start && !win_ok;

    // Widths fit in 9 bits once the window is known valid (max 320 / 480).
    assign xw   = x1 - x0 + 9'd1;
    assign yw   = y1 - y0 + 9'd1;
    assign npix = {9'd0, xw} * {9'd0, yw};

    assign dly_hit = ((state_q == S_WAIT_PWR) && (dly_q == PWR_DELAY - 1)) ||
                     ((state_q == S_WAIT_SLP) && (dly_q == SLP_DELAY - 1));

    // A pulse only consumes a pixel if one was actually being presented.
    assign pix_avail = src_sel_q ? (ent_q != 2'd0) : 1'b1;
    assign pix_pulse = (state_q == S_PIXELS) && tc && pix_avail;
    assign last_pix  = pix_pulse && (rem_q == 18'd1);
    assign pix_ready = (state_q == S_PIXELS) && src_sel_q && (ent_q < 2'd2) && (fetch_q != 18'd0);
    assign accept    = pix_valid && pix_ready;

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values of its neighbours, independent of block order.
        if (res) state_q <= S_WAIT_PWR;
        else     state_q <= state_d;
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_PWR: if (dly_hit)                      state_d = S_SLPOUT;
            S_SLPOUT:   if (tc)                           state_d = S_WAIT_SLP;
            S_WAIT_SLP: if (dly_hit)                      state_d = S_COLMOD;
            S_COLMOD:   if (tc && idx_q == 4'd1)          state_d = S_DISPON;
            S_DISPON:   if (tc)                           state_d = S_IDLE;
            S_IDLE:     if (start_ok)                     state_d = S_WIN;
            S_WIN:      if (tc && idx_q == WIN_LAST)      state_d = S_PIXELS;
            S_PIXELS:   if (last_pix)                     state_d = S_IDLE;
            default:                                      state_d = S_WAIT_PWR;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // In a pulse cycle the lines already show the following word, so the
    // controller can latch back-to-back words without a bubble.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // through the block leaves a value held, which would infer a latch.
        cmd     = 1'b0;
        data    = 1'b0;
        data_in = 16'h0000;
        ww      = 17'd0;
        case (state_q)
            S_SLPOUT: begin
                if (!tc) begin
                    cmd     = 1'b1;
                    data_in = CMD_SLPOUT;
                end
            end
            S_COLMOD: begin
                if ((idx_q == 4'd0) != tc) begin
                    // word 0 without pulse, or word 1 with pulse: show command
                    cmd     = 1'b1;
                    data_in = (idx_q == 4'd0) ? CMD_COLMOD : CMD_DISPON;
                end else if (idx_q == 4'd0 || !tc) begin
                    data    = 1'b1;
                    data_in = PAR_COLMOD;
                end
            end
            S_DISPON: begin
                if (!tc) begin
                    cmd     = 1'b1;
                    data_in = CMD_DISPON;
                end
            end
            S_WIN: begin
                if (!tc || idx_q != WIN_LAST) begin
                    ww      = win_word(tc ? idx_q + 4'd1 : idx_q, x0_q, x1_q, y0_q, y1_q);
                    cmd     = ww[16];
                    data    = !ww[16];
                    data_in = ww[15:0];
                end else if (!src_sel_q) begin
                    // stream buffer only starts filling in PIXELS, so it is empty here
                    data    = 1'b1;
                    data_in = color_q;
                end
            end
            S_PIXELS: begin
                if (!src_sel_q) begin
                    if (!last_pix) begin
                        data    = 1'b1;
                        data_in = color_q;
                    end
                end else if (pix_pulse) begin
                    if (!last_pix && ent_q == 2'd2) begin
                        data    = 1'b1;
                        data_in = pbuf_q[1];
                    end
                end else if (ent_q != 2'd0) begin
                    data    = 1'b1;
                    data_in = pbuf_q[0];
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign init_done = init_done_q;
    assign done      = done_q;
    assign err       = err_q;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (res) begin
            dly_q       <= '0;
            idx_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            src_sel_q   <= 1'b0;
            color_q     <= '0;
            rem_q       <= '0;
            fetch_q     <= '0;
            ent_q       <= '0;
            // NOTE: the two-entry prefetch store is small and must read as
            // empty/zero after an abort, so it is reset like any register.
            pbuf_q[0]   <= '0;
            pbuf_q[1]   <= '0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= last_pix;
            err_q  <= start_bad;

            if ((state_q == S_WAIT_PWR || state_q == S_WAIT_SLP) && !dly_hit)
                dly_q <= dly_q + 32'd1;
            else
                dly_q <= '0;

            if (state_d != state_q)
                idx_q <= '0;
            else if (tc && (state_q == S_COLMOD || state_q == S_WIN))
                idx_q <= idx_q + 4'd1;

            if (state_q == S_DISPON && tc)
                init_done_q <= 1'b1;

            if (start_ok) begin
                x0_q      <= x0;
                x1_q      <= x1;
                y0_q      <= y0;
                y1_q      <= y1;
                src_sel_q <= src_sel;
                color_q   <= color;
                rem_q     <= npix;
                fetch_q   <= npix;
                ent_q     <= '0;
            end

            if (pix_pulse)
                rem_q <= rem_q - 18'd1;

            if (accept)
                fetch_q <= fetch_q - 18'd1;

            // Simultaneous accept and pulse can only happen with one entry
            // (ready is low when full, pulse needs data), so the new pixel
            // simply replaces the head and occupancy is unchanged.
            if (state_q == S_PIXELS && src_sel_q) begin
                case ({accept, pix_pulse})
                    2'b10: begin
                        pbuf_q[ent_q[0]] <= pix_data;
                        ent_q            <= ent_q + 2'd1;
                    end
                    2'b01: begin
                        pbuf_q[0] <= pbuf_q[1];
                        ent_q     <= ent_q - 2'd1;
                    end
                    2'b11:   pbuf_q[0] <= pix_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hx8357_fill_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hx8357_fill_sequencer
//
// Drives hx8357_fill_sequencer with short init delays and a write-controller
// model that latches each presented word mid-cycle and answers with a
// transmission_cmpl pulse after 0..2 cycles. A table of constant-color fills
// (valid and rejected windows) is applied in a loop; stream fill, a fill whose
// pixel count exceeds 16 bits, a full-screen window and reset-abort cases are
// written out by hand.
// -----------------------------------------------------------------------------
module tb_hx8357_fill_sequencer;

    localparam int unsigned PWR = 4;
    localparam int unsigned SLP = 8;

    logic        clk = 1'b0;
    logic        res, start, src_sel, pix_valid, tc;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color, pix_data, data_in;
    logic        pix_ready, init_done, busy, done, err, cmd, data;

    always #5 clk = ~clk;

    hx8357_fill_sequencer #(.PWR_DELAY(PWR), .SLP_DELAY(SLP)) dut (
        .clk(clk), .res(res), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .src_sel(src_sel), .color(color),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .init_done(init_done), .busy(busy), .done(done), .err(err),
        .cmd(cmd), .data(data), .data_in(data_in),
        .transmission_cmpl(tc)
    );

    typedef struct {
        logic        c;
        logic        d;
        logic [15:0] w;
        logic        idone;
        int          cyc;
    } word_t;

    typedef struct {
        logic [8:0]  x0, x1, y0, y1;
        logic [15:0] col;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    word_t cap[$];
    int    pulse_edge[$];
    int    cyc = 0;
    int    done_cnt = 0, err_cnt = 0, both_cnt = 0;
    bit    fast = 1'b0;
    int    n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (cmd && data) both_cnt++;
    end

    // Write-controller model.
    initial begin
        tc = 1'b0;
        forever begin
            @(negedge clk);
            tc = 1'b0;
            #1;
            if (cmd || data) begin
                cap.push_back('{cmd, data, data_in, init_done, cyc});
                if (!fast) repeat ($urandom_range(0, 2)) @(negedge clk);
                tc = 1'b1;
                pulse_edge.push_back(cyc + 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] exp_win(input int i, input logic [8:0] a0, input logic [8:0] a1,
                                            input logic [8:0] b0, input logic [8:0] b1);
        logic [17:0] w [11];
        w = '{{2'b10, 16'h002A},
              {2'b01, 15'd0, a0[8]}, {2'b01, 8'd0, a0[7:0]},
              {2'b01, 15'd0, a1[8]}, {2'b01, 8'd0, a1[7:0]},
              {2'b10, 16'h002B},
              {2'b01, 15'd0, b0[8]}, {2'b01, 8'd0, b0[7:0]},
              {2'b01, 15'd0, b1[8]}, {2'b01, 8'd0, b1[7:0]},
              {2'b10, 16'h002C}};
        return w[i];
    endfunction

    // Count window-word mismatches between captured words base.. and the model.
    function automatic int win_errors(input int base, input logic [8:0] a0, input logic [8:0] a1,
                                      input logic [8:0] b0, input logic [8:0] b1);
        int bad = 0;
        for (int i = 0; i < 11; i++) begin
            if (base + i >= cap.size()) bad++;
            else if ({cap[base+i].c, cap[base+i].d, cap[base+i].w} !== exp_win(i, a0, a1, b0, b1)) bad++;
        end
        return bad;
    endfunction

    task automatic reset_and_init(input string tag);
        int r_edge, base, t;
        res = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        r_edge = cyc;
        base = cap.size();
        #2;
        check({tag, "_reset_outputs"},
              {busy, init_done, done, err, pix_ready, cmd, data, data_in}, {1'b1, 6'd0, 16'h0000});
        t = 0;
        while (!init_done && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        check({tag, "_init_done"}, init_done, 1'b1);
        check({tag, "_init_word_count"}, cap.size() - base, 4);
        if (cap.size() - base >= 4) begin
            check({tag, "_w_slpout"}, {cap[base].c, cap[base].d, cap[base].w}, {2'b10, 16'h0011});
            check({tag, "_w_colmod"}, {cap[base+1].c, cap[base+1].d, cap[base+1].w}, {2'b10, 16'h003A});
            check({tag, "_w_colpar"}, {cap[base+2].c, cap[base+2].d, cap[base+2].w}, {2'b01, 16'h0055});
            check({tag, "_w_dispon"}, {cap[base+3].c, cap[base+3].d, cap[base+3].w}, {2'b10, 16'h0029});
            check({tag, "_pwr_gap"}, cap[base].cyc - r_edge, PWR);
            check({tag, "_slp_gap"}, cap[base+1].cyc - pulse_edge[base], SLP);
            check({tag, "_init_low_at_dispon"}, cap[base+3].idone, 1'b0);
        end
    endtask

    task automatic start_fill(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] b0,
                              input logic [8:0] b1, input logic s, input logic [15:0] col);
        @(negedge clk);
        x0 = a0; x1 = a1; y0 = b0; y1 = b1;
        src_sel = s;
        color = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t vt [9];

    initial begin
        int base, db, eb, t, bad, k, late, n;

        vt[0] = '{9'd0,   9'd1,   9'd0,  9'd0,   16'hF800, 1'b0, 2};
        vt[1] = '{9'd0,   9'd320, 9'd0,  9'd0,   16'h1111, 1'b1, 0};
        vt[2] = '{9'd0,   9'd0,   9'd5,  9'd4,   16'h2222, 1'b1, 0};
        vt[3] = '{9'd3,   9'd2,   9'd0,  9'd0,   16'h3333, 1'b1, 0};
        vt[4] = '{9'd0,   9'd0,   9'd0,  9'd480, 16'h4444, 1'b1, 0};
        vt[5] = '{9'd10,  9'd12,  9'd20, 9'd21,  16'h07E0, 1'b0, 6};
        vt[6] = '{9'd5,   9'd5,   9'd0,  9'd479, 16'h001F, 1'b0, 480};
        vt[7] = '{9'd300, 9'd319, 9'd470, 9'd479, 16'h1234, 1'b0, 200};
        vt[8] = '{9'd7,   9'd7,   9'd9,  9'd9,   16'hABCD, 1'b0, 1};

        res = 1'b1; start = 1'b0; src_sel = 1'b0; pix_valid = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; pix_data = '0;

        reset_and_init("por");
        check("idle_busy", busy, 1'b0);

        // ------------------------------------------------ constant-fill table
        for (int v = 0; v < 9; v++) begin
            base = cap.size(); db = done_cnt; eb = err_cnt;
            start_fill(vt[v].x0, vt[v].x1, vt[v].y0, vt[v].y1, 1'b0, vt[v].col);
            #2;
            check($sformatf("v%0d_err_next_cycle", v), err, vt[v].exp_err);
            t = 0;
            while (!vt[v].exp_err && done_cnt == db && t < (11 + vt[v].exp_n) * 4 + 50) begin
                @(negedge clk);
                #2;
                t++;
            end
            repeat (6) @(negedge clk);
            #2;
            check($sformatf("v%0d_done_count", v), done_cnt - db, vt[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_err_count", v), err_cnt - eb, vt[v].exp_err ? 1 : 0);
            check($sformatf("v%0d_word_count", v), cap.size() - base,
                  vt[v].exp_err ? 0 : 11 + vt[v].exp_n);
            check($sformatf("v%0d_idle", v), busy, 1'b0);
            if (!vt[v].exp_err) begin
                check($sformatf("v%0d_window_words", v),
                      win_errors(base, vt[v].x0, vt[v].x1, vt[v].y0, vt[v].y1), 0);
                bad = 0;
                for (int i = base + 11; i < cap.size(); i++)
                    if ({cap[i].c, cap[i].d, cap[i].w} !== {2'b01, vt[v].col}) bad++;
                check($sformatf("v%0d_pixel_words", v), bad, 0);
            end
        end

        // -------------------------------------- stream 3x3 with random valid
        base = cap.size(); db = done_cnt;
        start_fill(9'd2, 9'd4, 9'd1, 9'd3, 1'b1, 16'h0000);
        k = 1; late = 0; t = 0;
        while (done_cnt == db && t < 400) begin
            @(negedge clk);
            #2;
            t++;
            if (k <= 9) begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_data = 16'(k);
                if (pix_valid && pix_ready) k++;
            end else begin
                pix_valid = 1'b0;
                if (pix_ready) late++;
            end
        end
        repeat (4) @(negedge clk);
        #2;
        check("stream_done_count", done_cnt - db, 1);
        check("stream_word_count", cap.size() - base, 20);
        check("stream_window_words", win_errors(base, 9'd2, 9'd4, 9'd1, 9'd3), 0);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (base + 11 + i >= cap.size() ||
                {cap[base+11+i].c, cap[base+11+i].d, cap[base+11+i].w} !== {2'b01, 16'(i + 1)}) bad++;
        check("stream_pixels_in_order", bad, 0);
        check("stream_ready_after_last", late, 0);

        // --------------------------- fill with more than 65535 pixels, x1=319
        fast = 1'b1;
        base = cap.size(); db = done_cnt;
        start_fill(9'd0, 9'd319, 9'd0, 9'd204, 1'b0, 16'h5A5A);
        t = 0;
        while (done_cnt == db && t < 70000) begin
            @(negedge clk);
            #2;
            t++;
        end
        repeat (4) @(negedge clk);
        #2;
        fast = 1'b0;
        n = cap.size() - base;
        check("big_done_count", done_cnt - db, 1);
        check("big_word_count", n, 11 + 65600);
        check("big_window_words", win_errors(base, 9'd0, 9'd319, 9'd0, 9'd204), 0);
        bad = 0;
        for (int i = base + 11; i < cap.size(); i++)
            if ({cap[i].c, cap[i].d, cap[i].w} !== {2'b01, 16'h5A5A}) bad++;
        check("big_pixel_words", bad, 0);

        // ---------------------- full-screen window, aborted by reset mid-fill
        base = cap.size(); db = done_cnt; eb = err_cnt;
        start_fill(9'd0, 9'd319, 9'd0, 9'd479, 1'b0, 16'h0F0F);
        t = 0;
        while (cap.size() - base < 111 && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("full_err_count", err_cnt - eb, 0);
        check("full_window_words", win_errors(base, 9'd0, 9'd319, 9'd0, 9'd479), 0);
        check("full_busy", busy, 1'b1);
        check("full_no_done", done_cnt - db, 0);
        reset_and_init("full_abort");

        // ------------------------------ stream 3x3, reset during pixel 5 of 9
        base = cap.size();
        start_fill(9'd0, 9'd2, 9'd0, 9'd2, 1'b1, 16'h0000);
        k = 1; t = 0;
        while (cap.size() - base < 16 && t < 300) begin
            @(negedge clk);
            #2;
            t++;
            pix_valid = 1'b1;
            pix_data = 16'(k);
            if (pix_ready) k++;
        end
        check("abort_reached_pixel5", cap.size() - base, 16);
        check("abort_pixel5_value", {cap[cap.size()-1].d, cap[cap.size()-1].w}, {1'b1, 16'd5});
        reset_and_init("pix5_abort");

        check("cmd_data_never_both", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
